// File: rtl/dmem_lsu.sv
// dmem_lsu: byte-addressed RV32 data memory with lane-merging stores, extending loads,
// programmable read latency and fault reporting over valid/ready request/response channels.
module dmem_lsu #(
   parameter int ADDR_WIDTH   = 32,
   parameter int DEPTH_WORDS  = 1024,
   parameter int READ_LATENCY = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_wen,
   input  logic [2:0]            req_type,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [31:0]           req_wd,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [31:0]           rsp_rd,
   output logic                  rsp_err
);
   localparam int IW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t state, state_nx;
   logic [2:0] cnt;
   logic [31:0] mem [DEPTH_WORDS];
   logic [31:0] rd_q, wdata, word, sh, ld_data;
   logic err_q, accept, in_range, mis, ld_ok, st_ok, bad;
   logic [1:0] off;
   logic [IW-1:0] widx;
   logic [3:0] be;
   assign off      = req_addr[1:0];
   assign widx     = req_addr[IW+1:2];
   assign in_range = {2'b00, req_addr[ADDR_WIDTH-1:2]} < ADDR_WIDTH'(DEPTH_WORDS);
   assign rsp_rd   = rd_q;
   assign rsp_err  = err_q;
   // Decode, lane enables and load extraction all act on the live request at acceptance.
   always_comb begin
      ld_ok   = (req_type[1:0] != 2'b11) & ~(req_type[2] & req_type[1]);
      st_ok   = ~req_type[2] & (req_type[1:0] != 2'b11);
      mis     = ((req_type[1:0] == 2'b01) & off[0]) | ((req_type[1:0] == 2'b10) & (off != 2'b00));
      bad     = ~in_range | mis | (req_wen ? ~st_ok : ~ld_ok);
      be      = (req_type[1:0] == 2'b00) ? 4'b0001 << off :
                (req_type[1:0] == 2'b01) ? 4'b0011 << off : 4'b1111;
      wdata   = (req_type[1:0] == 2'b00) ? {4{req_wd[7:0]}} :
                (req_type[1:0] == 2'b01) ? {2{req_wd[15:0]}} : req_wd;
      word    = mem[widx];
      sh      = word >> {off, 3'b000};
      ld_data = (req_type[1:0] == 2'b00) ? {{24{~req_type[2] & sh[7]}}, sh[7:0]} :
                (req_type[1:0] == 2'b01) ? {{16{~req_type[2] & sh[15]}}, sh[15:0]} : word;
   end
   always_comb begin
      req_ready = rst_n & ((state == IDLE) | ((state == RESP) & rsp_ready));
      rsp_valid = state == RESP;
      accept    = req_valid & req_ready;
      state_nx  = accept ? ((READ_LATENCY > 1) ? WAIT : RESP) :
                  (state == WAIT) ? ((cnt == '0) ? RESP : WAIT) :
                  ((state == RESP) & rsp_ready) ? IDLE : state;
   end
   always_ff @(posedge clk) begin
      if (accept & req_wen & ~bad)
         for (int k = 0; k < 4; k++)
            if (be[k]) mem[widx][8*k +: 8] <= wdata[8*k +: 8];
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
         rd_q  <= '0;
         err_q <= 1'b0;
      end else begin
         state <= state_nx;
         if (accept) begin
            cnt   <= 3'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
            rd_q  <= (bad | req_wen) ? 32'h0 : ld_data;
            err_q <= bad;
         end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - 3'd1;
         end
      end
   end
endmodule

// File: doc/dmem_lsu.md
Name: dmem_lsu

Overview:
- Byte-addressed RV32 data memory with a valid/ready request channel and a valid/ready response channel.
- Store bytes and halfwords into the correct lane and leave the other lanes of the word untouched.
- Sign- or zero-extend loads from any legal lane; read latency is programmable.
- Report misaligned, out-of-range and illegal-type accesses as errors instead of touching memory.
- Sits between the processor's MEM stage (or a multi-cycle LSU) and the word array; one request outstanding at a time.

Parameters:
- ADDR_WIDTH, 32, byte-address width of req_addr.
- DEPTH_WORDS, 1024, number of 32-bit words; legal byte addresses are 0 .. 4*DEPTH_WORDS-1.
- READ_LATENCY, 1, cycles from request acceptance to rsp_valid; legal range 1..8.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  block can accept a request this cycle.
- req_wen  input  1  1 = store, 0 = load.
- req_type  input  3  funct3: LB/SB=000, LH/SH=001, LW/SW=010, LBU=100, LHU=101.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wd  input  32  store data, right-aligned.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  consumer accepts the response.
- rsp_rd  output  32  load data, extended; 0 for stores and errors.
- rsp_err  output  1  access faulted.

Behaviour:
- Reset is asynchronous and active-low: clk is the only clock and rst_n is the asynchronous active-low reset.
- On rst_n = 0:
  - state goes to IDLE.
  - rsp_valid = 0, rsp_rd = 0, rsp_err = 0, latency counter = 0.
  - req_ready = 1 once reset is released.
  - Memory contents are not cleared.
  - Reset asserted mid-operation drops any pending response. A store already written stays written.
- FSM states:
  - IDLE: req_ready = 1. On handshake (req_valid & req_ready), go to WAIT if READ_LATENCY > 1, otherwise go to RESP.
  - WAIT: req_ready = 0. The counter loads READ_LATENCY-2 at acceptance and decrements. Go to RESP when the counter reaches 0.
  - RESP: rsp_valid = 1, and rsp_rd/rsp_err stay stable until rsp_ready.
    - req_ready = rsp_ready, so a back-to-back accept is possible in the same cycle.
    - On rsp_ready with a new handshake, start the new request as from IDLE.
    - On rsp_ready with no new request, go to IDLE.
- Latency: a request accepted at edge T gives rsp_valid high from the cycle after edge T+READ_LATENCY-1. That is READ_LATENCY cycles after the accept cycle.
- Access decode at acceptance:
  - word index = addr[ADDR_WIDTH-1:2], offset = addr[1:0].
  - Error if any of the following holds:
    - word index >= DEPTH_WORDS.
    - type is halfword and offset[0] = 1.
    - type is word and offset != 0.
    - load type is 011, 110 or 111.
    - store type is anything other than 000, 001 or 010.
  - On error: no memory write, rsp_err = 1, rsp_rd = 0.
- Store: the write happens at the acceptance edge using byte enables.
  - SB writes byte lane = offset.
  - SH writes lanes {offset+1, offset}.
  - SW writes all 4 lanes.
  - Unselected lanes are preserved.
  - Response has rsp_err = 0 and rsp_rd = 0.
- Load: the word is read at the acceptance edge and held in a pipeline register, so a load accepted after a store completes sees the stored data.
  - LB/LBU extract bits [8*offset+7 : 8*offset].
  - LH/LHU extract bits [8*offset+15 : 8*offset].
  - LB and LH sign-extend; LBU and LHU zero-extend.
- Little-endian lane order: byte 0 = bits [7:0].
- req_* inputs are ignored whenever req_ready = 0.
- Only the registered request is used after acceptance, so later changes on req_* do not disturb an in-flight access.

Test Plan:
- LATENCY=1: SW 0xDEADBEEF @0x10, then LW @0x10 → store rsp err=0 rd=0; load rsp_rd=0xDEADBEEF exactly 1 cycle after accept.
- Lane merge: SW 0x11223344 @0x20, SB 0xAA @0x22, SH 0x5566 @0x20, LW @0x20 → 0x11AA5566.
- Extension: word @0x30 = 0x80F07F01.
  - LB @0x33 → 0xFFFFFF80; LBU @0x33 → 0x00000080.
  - LH @0x32 → 0xFFFF80F0; LHU @0x30 → 0x00007F01.
- Faults:
  - LH @0x31 → err=1, rd=0.
  - SW @0x22 → err=1, and word @0x20 is unchanged.
  - LW @4*DEPTH_WORDS → err=1.
  - load type 011 → err=1.
- READ_LATENCY=4 with backpressure: accept at cycle 0 → rsp_valid at cycle 4.
  - Hold rsp_ready=0 for 3 cycles: rsp_rd stable, req_ready=0.
  - Raise rsp_ready with req_valid: next request accepted in the same cycle, and its response arrives 4 cycles later.
- Reset mid-WAIT: pull rst_n low 2 cycles after accepting a load → rsp_valid=0 immediately, no response after release, req_ready=1. A store issued before reset is still readable after reset.
